stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/cpu_seq_pkg.sv | 44 ++++
 rtl/stage_sequencer_if.sv | 36 +++
 rtl/op_class.sv | 17 +
 rtl/stage_sequencer.sv | 114 +++++++++++
 tb/tb_stage_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the instruction stage sequencer: state encodings,
// opcode constants, timeout default and the opcode-class payload.
package cpu_seq_pkg;

  localparam int unsigned OP_W            = 6;
  localparam int unsigned ST_W            = 3;
  localparam int unsigned TO_W            = 4;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned MEM_TIMEOUT_DEF = 15;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_IF     = 3'd1,
    ST_ID     = 3'd2,
    ST_ALU    = 3'd3,
    ST_MEM    = 3'd4,
    ST_RB     = 3'd5,
    ST_HALTED = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam logic [OP_W-1:0] OP_HLT = 6'b000000;
  localparam logic [OP_W-1:0] OP_LDI = 6'b010000;
  localparam logic [OP_W-1:0] OP_LUI = 6'b010001;
  localparam logic [OP_W-1:0] OP_LW  = 6'b011000;
  localparam logic [OP_W-1:0] OP_SW  = 6'b011001;
  localparam logic [OP_W-1:0] OP_LB  = 6'b011010;
  localparam logic [OP_W-1:0] OP_SB  = 6'b011011;
  localparam logic [OP_W-1:0] OP_JMP = 6'b100000;
  localparam logic [OP_W-1:0] OP_JR  = 6'b100001;
  localparam logic [OP_W-1:0] OP_BEQ = 6'b100010;
  localparam logic [OP_W-1:0] OP_BLT = 6'b100011;

  typedef struct packed {
    logic is_halt;
    logic is_mem;
  } op_class_t;

  // True for the load/store opcodes that need a data-memory stage
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_LB) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the sequencer (slave) and its driver (master).
//   inputs to sequencer : start, stall, opcode, imem_ready, dmem_ready
//   outputs             : stage strobes, state, busy, halted, error, instr_count
interface stage_sequencer_if;
  import cpu_seq_pkg::*;

  logic             start;
  logic             stall;
  logic [OP_W-1:0]  opcode;
  logic             imem_ready;
  logic             dmem_ready;

  logic             IF_en;
  logic             ID_en;
  logic             ALU_en;
  logic             MEM_en;
  logic             RB_BR_en;
  logic [ST_W-1:0]  state;
  logic             busy;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, stall, opcode, imem_ready, dmem_ready,
    input  IF_en, ID_en, ALU_en, MEM_en, RB_BR_en,
    input  state, busy, halted, error, instr_count
  );

  modport slave (
    input  start, stall, opcode, imem_ready, dmem_ready,
    output IF_en, ID_en, ALU_en, MEM_en, RB_BR_en,
    output state, busy, halted, error, instr_count
  );

endinterface

// File: rtl/op_class.sv
// Combinational opcode classifier.
//   i_opcode : instruction opcode
//   o_class  : {is_halt, is_mem}
module op_class
  import cpu_seq_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  output op_class_t       o_class
);

  always_comb begin
    o_class         = '0;
    o_class.is_halt = (i_opcode == OP_HLT);
    o_class.is_mem  = is_mem_op(i_opcode);
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer IF -> ID -> ALU -> [MEM] -> RB,
// with memory-wait timeout, global stall and terminal HALTED/ERROR states.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : control/status bundle (slave side)
module stage_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  stage_sequencer_if.slave  bus
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_next;
  logic [OP_W-1:0]  r_op_q;
  logic [OP_W-1:0]  w_cls_op;
  logic [TO_W-1:0]  r_to_cnt;
  logic [CNT_W-1:0] r_instr_count;
  op_class_t        w_class;
  logic             w_waiting;
  logic             w_wait_ready;
  logic             w_timeout;

  // ID decides on the live opcode; ALU decides on the copy latched in ID
  assign w_cls_op = (r_state == ST_ID) ? bus.opcode : r_op_q;

  op_class u_op_class (
    .i_opcode (w_cls_op),
    .o_class  (w_class)
  );

  // Ready line that matters in the current wait state
  assign w_waiting    = (r_state == ST_IF) || (r_state == ST_MEM);
  assign w_wait_ready = (r_state == ST_MEM) ? bus.dmem_ready : bus.imem_ready;
  assign w_timeout    = w_waiting && !w_wait_ready && (r_to_cnt == TO_LIMIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; stall overrides every transition
  always_comb begin
    w_next = r_state;
    if (!bus.stall) begin
      case (r_state)
        ST_IDLE: if (bus.start) w_next = ST_IF;
        ST_IF: begin
          if (bus.imem_ready)  w_next = ST_ID;
          else if (w_timeout)  w_next = ST_ERROR;
        end
        ST_ID:   w_next = w_class.is_halt ? ST_HALTED : ST_ALU;
        ST_ALU:  w_next = w_class.is_mem  ? ST_MEM    : ST_RB;
        ST_MEM: begin
          if (bus.dmem_ready)  w_next = ST_RB;
          else if (w_timeout)  w_next = ST_ERROR;
        end
        ST_RB:   w_next = ST_IF;
        default: w_next = r_state;
      endcase
    end
  end

  // Opcode latch, wait counter and retired-instruction counter.
  // The wait counter sits at zero outside IF/MEM, so it is clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_q        <= '0;
      r_to_cnt      <= '0;
      r_instr_count <= '0;
    end else if (!bus.stall) begin
      if (r_state == ST_ID) r_op_q <= bus.opcode;

      if (w_waiting && !w_wait_ready && !w_timeout) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                                          r_to_cnt <= '0;

      if ((r_state == ST_RB) && (r_instr_count != '1))
        r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  // Output decode of the registered state
  always_comb begin
    bus.IF_en       = 1'b0;
    bus.ID_en       = 1'b0;
    bus.ALU_en      = 1'b0;
    bus.MEM_en      = 1'b0;
    bus.RB_BR_en    = 1'b0;
    bus.busy        = 1'b0;
    bus.halted      = 1'b0;
    bus.error       = 1'b0;
    bus.state       = ST_W'(r_state);
    bus.instr_count = r_instr_count;
    case (r_state)
      ST_IF:     begin bus.IF_en    = 1'b1; bus.busy = 1'b1; end
      ST_ID:     begin bus.ID_en    = 1'b1; bus.busy = 1'b1; end
      ST_ALU:    begin bus.ALU_en   = 1'b1; bus.busy = 1'b1; end
      ST_MEM:    begin bus.MEM_en   = 1'b1; bus.busy = 1'b1; end
      ST_RB:     begin bus.RB_BR_en = 1'b1; bus.busy = 1'b1; end
      ST_HALTED: bus.halted = 1'b1;
      ST_ERROR:  bus.error  = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: vector table plus hand-written
// timeout, boundary and asynchronous-reset sequences.
module tb_stage_sequencer;
  import cpu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stage_sequencer_if bus();

  stage_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        start;
    logic        stall;
    logic [5:0]  op;
    logic        imem;
    logic        dmem;
    logic [2:0]  st;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic start, input logic stall, input logic [5:0] op,
                              input logic imem, input logic dmem,
                              input logic [2:0] st, input logic [15:0] cnt);
    vec_t v;
    v.start = start; v.stall = stall; v.op = op; v.imem = imem; v.dmem = dmem;
    v.st = st; v.cnt = cnt;
    return v;
  endfunction

  // Expected {state, IF,ID,ALU,MEM,RB, busy, halted, error, instr_count}
  function automatic logic [26:0] model(input logic [2:0] st, input logic [15:0] cnt);
    logic [4:0] stb;
    logic       bsy;
    stb = 5'b00000;
    case (st)
      3'd1: stb = 5'b10000;
      3'd2: stb = 5'b01000;
      3'd3: stb = 5'b00100;
      3'd4: stb = 5'b00010;
      3'd5: stb = 5'b00001;
      default: stb = 5'b00000;
    endcase
    bsy = (st >= 3'd1) && (st <= 3'd5);
    return {st, stb, bsy, (st == 3'd6), (st == 3'd7), cnt};
  endfunction

  function automatic logic [26:0] snap();
    return {bus.state, bus.IF_en, bus.ID_en, bus.ALU_en, bus.MEM_en, bus.RB_BR_en,
            bus.busy, bus.halted, bus.error, bus.instr_count};
  endfunction

  task automatic check(input string name, input logic [2:0] st, input logic [15:0] cnt);
    logic [26:0] got;
    logic [26:0] exp;
    got = snap();
    exp = model(st, cnt);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got state/strobes/flags/count=%h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic start, input logic stall, input logic [5:0] op,
                       input logic imem, input logic dmem);
    bus.start = start; bus.stall = stall; bus.opcode = op;
    bus.imem_ready = imem; bus.dmem_ready = dmem;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, OP_LDI, 1'b1, 1'b1);
    rst_n = 1'b0;
    tick();
    check("reset", 3'd0, 16'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Inputs present in the cycle before the edge; expectation after the edge
    tbl.push_back(mk(0,0,OP_LDI,1,1, 3'd0, 16'd0));
    tbl.push_back(mk(1,0,OP_LDI,1,1, 3'd1, 16'd0));
    tbl.push_back(mk(0,0,OP_LDI,1,1, 3'd2, 16'd0));
    tbl.push_back(mk(1,0,OP_LDI,1,1, 3'd3, 16'd0));
    tbl.push_back(mk(0,0,OP_LDI,1,1, 3'd5, 16'd0));
    tbl.push_back(mk(0,0,OP_LW ,1,1, 3'd1, 16'd1));
    tbl.push_back(mk(0,0,OP_LW ,1,1, 3'd2, 16'd1));
    tbl.push_back(mk(0,0,OP_LW ,1,1, 3'd3, 16'd1));
    tbl.push_back(mk(0,0,OP_LW ,1,0, 3'd4, 16'd1));
    tbl.push_back(mk(0,0,OP_LW ,1,0, 3'd4, 16'd1));
    tbl.push_back(mk(0,0,OP_LW ,1,0, 3'd4, 16'd1));
    tbl.push_back(mk(0,0,OP_LW ,1,0, 3'd4, 16'd1));
    tbl.push_back(mk(0,0,OP_LW ,1,1, 3'd5, 16'd1));
    tbl.push_back(mk(0,0,OP_BEQ,1,1, 3'd1, 16'd2));
    tbl.push_back(mk(0,0,OP_BEQ,1,1, 3'd2, 16'd2));
    tbl.push_back(mk(0,0,OP_BEQ,1,1, 3'd3, 16'd2));
    tbl.push_back(mk(0,1,OP_BEQ,1,1, 3'd3, 16'd2));
    tbl.push_back(mk(1,1,OP_BEQ,1,1, 3'd3, 16'd2));
    tbl.push_back(mk(0,1,OP_BEQ,1,1, 3'd3, 16'd2));
    tbl.push_back(mk(0,0,OP_BEQ,1,1, 3'd5, 16'd2));
    tbl.push_back(mk(0,0,OP_SB ,1,1, 3'd1, 16'd3));
    tbl.push_back(mk(0,0,OP_SB ,1,1, 3'd2, 16'd3));
    tbl.push_back(mk(0,0,OP_SB ,1,1, 3'd3, 16'd3));
    tbl.push_back(mk(0,0,OP_SB ,1,1, 3'd4, 16'd3));
    tbl.push_back(mk(0,1,OP_SB ,1,1, 3'd4, 16'd3));
    tbl.push_back(mk(0,0,OP_SB ,1,1, 3'd5, 16'd3));
    tbl.push_back(mk(0,0,OP_JMP,1,1, 3'd1, 16'd4));
    tbl.push_back(mk(0,0,OP_JMP,1,1, 3'd2, 16'd4));
    tbl.push_back(mk(0,0,OP_JMP,1,1, 3'd3, 16'd4));
    tbl.push_back(mk(0,0,OP_JMP,1,1, 3'd5, 16'd4));
    tbl.push_back(mk(0,1,OP_JMP,1,1, 3'd5, 16'd4));
    tbl.push_back(mk(0,0,OP_HLT,1,1, 3'd1, 16'd5));
    tbl.push_back(mk(0,0,OP_HLT,1,1, 3'd2, 16'd5));
    tbl.push_back(mk(0,0,OP_HLT,1,1, 3'd6, 16'd5));
    tbl.push_back(mk(1,0,OP_HLT,1,1, 3'd6, 16'd5));
    tbl.push_back(mk(1,0,OP_LDI,1,1, 3'd6, 16'd5));

    rst_n = 1'b0;
    drive(1'b0, 1'b0, OP_LDI, 1'b1, 1'b1);
    #12;
    check("reset_initial", 3'd0, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].stall, tbl[i].op, tbl[i].imem, tbl[i].dmem);
      tick();
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].cnt);
    end

    // imem_ready stuck low: 16 cycles of IF, then ERROR (terminal)
    do_reset();
    drive(1'b1, 1'b0, OP_LDI, 1'b0, 1'b1);
    tick();
    check("if_to_enter", 3'd1, 16'd0);
    bus.start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("if_to_wait%0d", k), 3'd1, 16'd0);
    end
    tick();
    check("if_to_error", 3'd7, 16'd0);
    bus.start = 1'b1;
    bus.imem_ready = 1'b1;
    tick();
    check("error_terminal", 3'd7, 16'd0);

    // imem_ready rises exactly when the counter hits the limit: no ERROR
    do_reset();
    drive(1'b1, 1'b0, OP_LDI, 1'b0, 1'b1);
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    check("if_edge_still_if", 3'd1, 16'd0);
    bus.imem_ready = 1'b1;
    tick();
    check("if_edge_to_id", 3'd2, 16'd0);
    tick();
    check("if_edge_alu", 3'd3, 16'd0);

    // dmem_ready stuck low: 16 cycles of MEM, then ERROR
    do_reset();
    drive(1'b1, 1'b0, OP_SW, 1'b1, 1'b0);
    tick(); tick(); tick();
    bus.start = 1'b0;
    tick();
    check("mem_to_enter", 3'd4, 16'd0);
    for (int k = 0; k < 15; k++) tick();
    check("mem_to_last_wait", 3'd4, 16'd0);
    tick();
    check("mem_to_error", 3'd7, 16'd0);

    // Asynchronous reset in the middle of a MEM wait
    do_reset();
    drive(1'b1, 1'b0, OP_LDI, 1'b1, 1'b1);
    tick(); tick(); tick(); tick(); tick();
    check("ar_first_retired", 3'd1, 16'd1);
    drive(1'b0, 1'b0, OP_LB, 1'b1, 1'b0);
    tick(); tick(); tick();
    check("ar_in_mem", 3'd4, 16'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_immediate", 3'd0, 16'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, OP_LDI, 1'b1, 1'b1);
    tick();
    check("ar_idle_wait", 3'd0, 16'd0);
    bus.start = 1'b1;
    tick();
    check("ar_restart", 3'd1, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench completion");
    $fatal(1);
  end

endmodule
